// File: rtl/ppm_sram_writer_if.sv
// ppm_sram_writer_if: UART byte input, SRAM write port and status between writer and host
interface ppm_sram_writer_if;
  logic        Enable;
  logic [7:0]  Rx_data;
  logic        Rx_valid;
  logic        Flush;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        Busy;
  logic        Done;
  logic [17:0] Word_count;
  logic        Overflow;
  modport slave (
    input  Enable, Rx_data, Rx_valid, Flush,
    output SRAM_address, SRAM_write_data, SRAM_we_n, Busy, Done, Word_count, Overflow
  );
  modport master (
    output Enable, Rx_data, Rx_valid, Flush,
    input  SRAM_address, SRAM_write_data, SRAM_we_n, Busy, Done, Word_count, Overflow
  );
endinterface

// File: rtl/ppm_sram_writer.sv
// ppm_sram_writer: skips a PPM header from a UART byte stream and packs pixel byte pairs into SRAM words
module ppm_sram_writer #(
  parameter int          HEADER_LINES = 3,
  parameter int          MAX_WORDS    = 115200,
  parameter logic [17:0] BASE_ADDR    = 18'd0
) (
  input  logic             Clock_50,
  input  logic             Reset,
  ppm_sram_writer_if.slave bus
);
  localparam int NW = $clog2(HEADER_LINES + 2);
  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_HIGH, S_LOW, S_DONE} state_t;
  state_t        state_q, state_d;
  logic [NW-1:0] nl_q, nl_d;
  logic [7:0]    high_q, high_d;
  logic [17:0]   ptr_q, ptr_d, addr_q, addr_d, count_q, count_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          we_n_q, we_n_d, ovf_q, ovf_d, wr;
  logic [7:0]    wr_hi, wr_lo;
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state_q <= S_IDLE;
      nl_q    <= '0;
      high_q  <= '0;
      ptr_q   <= BASE_ADDR;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      wdata_q <= '0;
      we_n_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nl_q    <= nl_d;
      high_q  <= high_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      we_n_q  <= we_n_d;
      ovf_q   <= ovf_d;
    end
  end
  always_comb begin
    state_d = state_q;
    nl_d    = nl_q;
    high_d  = high_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    we_n_d  = 1'b1;
    ovf_d   = ovf_q;
    wr      = 1'b0;
    wr_hi   = high_q;
    wr_lo   = 8'h00;
    case (state_q)
      S_IDLE: if (bus.Enable) begin
        state_d = S_HEADER;
        nl_d    = '0;
        count_d = '0;
        ptr_d   = BASE_ADDR;
      end
      S_HEADER: begin
        if (bus.Rx_valid && bus.Rx_data == 8'h0A) begin
          nl_d = nl_q + NW'(1);
          if (nl_d == NW'(HEADER_LINES)) state_d = S_HIGH;
        end
        if (bus.Flush) state_d = S_DONE;
      end
      S_HIGH: begin
        if (bus.Rx_valid) begin
          high_d  = bus.Rx_data;
          state_d = S_LOW;
          wr      = bus.Flush;
          wr_hi   = bus.Rx_data;
        end else if (bus.Flush) state_d = S_DONE;
      end
      S_LOW: begin
        // a flush without a byte pads the pending high byte with zero
        wr    = bus.Rx_valid || bus.Flush;
        wr_lo = bus.Rx_valid ? bus.Rx_data : 8'h00;
      end
      S_DONE: begin
        if (bus.Rx_valid) ovf_d = 1'b1;
        if (!bus.Enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (wr) begin
      we_n_d  = 1'b0;
      addr_d  = ptr_q;
      wdata_d = {wr_hi, wr_lo};
      ptr_d   = ptr_q + 18'd1;
      count_d = count_q + 18'd1;
      state_d = (bus.Flush || count_q + 18'd1 == 18'(MAX_WORDS)) ? S_DONE : S_HIGH;
    end
  end
  assign bus.SRAM_address    = addr_q;
  assign bus.SRAM_write_data = wdata_q;
  assign bus.SRAM_we_n       = we_n_q;
  assign bus.Busy            = state_q == S_HEADER || state_q == S_HIGH || state_q == S_LOW;
  assign bus.Done            = state_q == S_DONE;
  assign bus.Word_count      = count_q;
  assign bus.Overflow        = ovf_q;
endmodule

// File: tb/tb_ppm_sram_writer.sv
// tb_ppm_sram_writer: directed checks of a default writer and a two-word-frame writer driven in lockstep
module tb_ppm_sram_writer;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, rxv = 1'b0, fl = 1'b0;
  logic [7:0] rxd = 8'h00;
  int n_chk = 0, n_pass = 0;
  int nwa = 0, nwb = 0, long_a = 0, long_b = 0, mark;
  logic [17:0] wa_a [8], wa_b [8];
  logic [15:0] wd_a [8], wd_b [8];
  logic prev_a = 1'b0, prev_b = 1'b0;
  ppm_sram_writer_if ia ();
  ppm_sram_writer_if ib ();
  assign ia.Enable = en;
  assign ia.Rx_data = rxd;
  assign ia.Rx_valid = rxv;
  assign ia.Flush = fl;
  assign ib.Enable = en;
  assign ib.Rx_data = rxd;
  assign ib.Rx_valid = rxv;
  assign ib.Flush = fl;
  ppm_sram_writer dut_a (.Clock_50(clk), .Reset(rst), .bus(ia));
  ppm_sram_writer #(.MAX_WORDS(2)) dut_b (.Clock_50(clk), .Reset(rst), .bus(ib));
  always #10 clk = ~clk;
  always @(negedge clk) begin
    if (!ia.SRAM_we_n) begin
      if (nwa < 8) begin
        wa_a[nwa] = ia.SRAM_address;
        wd_a[nwa] = ia.SRAM_write_data;
      end
      nwa++;
    end
    if (!ib.SRAM_we_n) begin
      if (nwb < 8) begin
        wa_b[nwb] = ib.SRAM_address;
        wd_b[nwb] = ib.SRAM_write_data;
      end
      nwb++;
    end
    if (!ia.SRAM_we_n && prev_a) long_a++;
    if (!ib.SRAM_we_n && prev_b) long_b++;
    prev_a = !ia.SRAM_we_n;
    prev_b = !ib.SRAM_we_n;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic put(input logic [7:0] b);
    rxd = b;
    rxv = 1'b1;
    @(negedge clk);
    rxv = 1'b0;
  endtask
  task automatic start();
    nwa = 0;
    nwb = 0;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask
  task automatic header();
    string s = "P6\n320 240\n255\n";
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask
  task automatic pulse_flush();
    fl = 1'b1;
    @(negedge clk);
    fl = 1'b0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " we_n"}, ia.SRAM_we_n, 1);
    chk({tag, " addr"}, ia.SRAM_address, 0);
    chk({tag, " wdata"}, ia.SRAM_write_data, 0);
    chk({tag, " busy"}, ia.Busy, 0);
    chk({tag, " done"}, ia.Done, 0);
    chk({tag, " wc"}, ia.Word_count, 0);
    chk({tag, " ovf"}, ia.Overflow, 0);
    chk({tag, " b ovf"}, ib.Overflow, 0);
  endtask
  initial begin
    tick(2);
    rst = 1'b0;
    chk_reset("rst");
    // header skip, single word
    start();
    chk("hdr busy", ia.Busy, 1);
    header();
    chk("hdr no write", nwa, 0);
    put(8'h12);
    put(8'h34);
    tick(2);
    chk("t1 writes", nwa, 1);
    chk("t1 addr", wa_a[0], 0);
    chk("t1 data", wd_a[0], 16'h1234);
    chk("t1 wc", ia.Word_count, 1);
    chk("t1 busy", ia.Busy, 1);
    pulse_flush();
    chk("t1 flush done", ia.Done, 1);
    chk("t1 flush no write", nwa, 1);
    tick(1);
    chk("t1 idle", ia.Done, 0);
    // odd byte count ended by flush
    start();
    header();
    put(8'hAB);
    put(8'hCD);
    put(8'hEF);
    pulse_flush();
    chk("t2 done", ia.Done, 1);
    chk("t2 b done", ib.Done, 1);
    tick(1);
    chk("t2 writes", nwa, 2);
    chk("t2 d0", wd_a[0], 16'hABCD);
    chk("t2 a0", wa_a[0], 0);
    chk("t2 d1", wd_a[1], 16'hEF00);
    chk("t2 a1", wa_a[1], 1);
    chk("t2 wc", ia.Word_count, 2);
    chk("t2 b writes", nwb, 2);
    // back-to-back strobes; instance b fills its two-word frame then overflows
    start();
    header();
    put(8'h01);
    put(8'h02);
    put(8'h03);
    put(8'h04);
    chk("t3 b done", ib.Done, 1);
    chk("t3 b busy", ib.Busy, 0);
    put(8'h05);
    tick(1);
    chk("t3 writes", nwa, 2);
    chk("t3 d0", wd_a[0], 16'h0102);
    chk("t3 d1", wd_a[1], 16'h0304);
    chk("t3 a1", wa_a[1], 1);
    chk("t3 single strobes", long_a, 0);
    chk("t3 b writes", nwb, 2);
    chk("t3 b a1", wa_b[1], 1);
    chk("t3 b ovf", ib.Overflow, 1);
    chk("t3 a ovf", ia.Overflow, 0);
    pulse_flush();
    tick(1);
    chk("t3 pad writes", nwa, 3);
    chk("t3 pad data", wd_a[2], 16'h0500);
    chk("t3 pad addr", wa_a[2], 2);
    chk("t3 b no 3rd", nwb, 2);
    chk("t3 b ovf sticky", ib.Overflow, 1);
    // reset mid-frame
    start();
    header();
    put(8'h11);
    put(8'h22);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mark = nwa;
    chk_reset("t4");
    tick(3);
    chk("t4 no strobe", nwa, mark);
    // byte and flush together in S_HIGH
    start();
    header();
    rxd = 8'h5A;
    rxv = 1'b1;
    fl = 1'b1;
    @(negedge clk);
    rxv = 1'b0;
    fl = 1'b0;
    chk("t5 we_n", ia.SRAM_we_n, 0);
    chk("t5 data", ia.SRAM_write_data, 16'h5A00);
    chk("t5 addr", ia.SRAM_address, 0);
    chk("t5 done", ia.Done, 1);
    tick(2);
    chk("t5 writes", nwa, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ppm_sram_writer.md
PPM_SRAM_WRITER -- requirements
Module: ppm_sram_writer

Interface
REQ-001 Parameter HEADER_LINES, default 3: number of 8'h0A bytes that terminate the PPM header.
REQ-002 Parameter MAX_WORDS, default 115200: SRAM words per frame (320x240x3 bytes / 2).
REQ-003 Parameter BASE_ADDR, default 18'd0: address of the first pixel word.
REQ-004 Clock_50  in  1  system clock; all logic samples on its rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 Enable  in  1  arms the block; sampled only in S_IDLE.
REQ-007 Rx_data  in  8  received UART byte; valid only when Rx_valid=1.
REQ-008 Rx_valid  in  1  single-cycle strobe, one per received byte.
REQ-009 Flush  in  1  single-cycle strobe from the UART timeout; ends the frame early.
REQ-010 SRAM_address  out  18  word address for the write.
REQ-011 SRAM_write_data  out  16  packed word, {first byte, second byte}.
REQ-012 SRAM_we_n  out  1  active-low write strobe, one cycle per word.
REQ-013 Busy  out  1  high in S_HEADER, S_HIGH and S_LOW.
REQ-014 Done  out  1  high in S_DONE.
REQ-015 Word_count  out  18  number of words written in this frame.
REQ-016 Overflow  out  1  sticky; set when a byte arrives in S_DONE.

Function
REQ-017 States are S_IDLE, S_HEADER, S_HIGH, S_LOW and S_DONE; the state register is one-hot or binary (implementer's choice).
REQ-018 S_IDLE: when Enable=1, go to S_HEADER, clear the newline counter and Word_count, and load the address pointer with BASE_ADDR.
REQ-019 S_HEADER: each Rx_valid byte is discarded; a byte equal to 8'h0A increments the newline counter.
REQ-020 S_HEADER exit: go to S_HIGH in the cycle the newline counter reaches HEADER_LINES; the next byte is pixel data.
REQ-021 S_HIGH: on Rx_valid, latch Rx_data as the high byte and go to S_LOW.
REQ-022 S_LOW: on Rx_valid, issue a write using {high, Rx_data}.
REQ-023 S_LOW exit: after the write, go to S_HIGH, or to S_DONE if Word_count+1 == MAX_WORDS.
REQ-024 Write timing: SRAM_we_n=0 for exactly one cycle, the cycle after the Rx_valid that completes the word.
REQ-025 Write data: SRAM_address and SRAM_write_data are registered and stable throughout the cycle in which SRAM_we_n=0.
REQ-026 After a write, the address pointer and Word_count each increment by 1 in the same cycle that SRAM_we_n=0.
REQ-027 Address arithmetic is 18-bit unsigned and wraps modulo 2^18 without error.
REQ-028 Back-to-back Rx_valid on consecutive cycles is accepted in S_HIGH and S_LOW; no byte is lost while a write strobe is active.
REQ-029 Flush in S_LOW: write {high, 8'h00}, then go to S_DONE.
REQ-030 Flush in S_HIGH or S_HEADER: go to S_DONE with no write.
REQ-031 Flush in S_IDLE or S_DONE: ignored.
REQ-032 Flush and Rx_valid in the same cycle: the byte is processed first (completing a word if in S_LOW), then the flush is applied from the resulting state; at most one write is issued.
REQ-033 S_DONE: Rx_valid sets Overflow, and no write is issued.
REQ-034 S_DONE exit: go to S_IDLE when Enable=0.
REQ-035 Enable deasserted in S_HEADER, S_HIGH or S_LOW has no effect.
REQ-036 SRAM_we_n is never 0 outside a write cycle defined in REQ-024 or REQ-029.

Reset
REQ-037 Reset=1 forces, on the next rising edge, S_IDLE with SRAM_we_n=1, SRAM_address=BASE_ADDR, SRAM_write_data=0, Busy=0, Done=0, Word_count=0, Overflow=0, newline counter=0 and high-byte register=0.
REQ-038 Reset mid-frame aborts any pending write; no SRAM_we_n=0 pulse occurs in the cycle after Reset is sampled.

Verification
REQ-039 Header skip: Enable, then send "P6\n320 240\n255\n" and bytes 8'h12, 8'h34 -> exactly one write, address 0, data 16'h1234, Word_count=1.
REQ-040 Full frame: send the header plus 230400 bytes -> 115200 writes with consecutive addresses 0..115199, then Done=1, Busy=0.
REQ-041 Odd flush: send the header and bytes 8'hAB, 8'hCD, 8'hEF, then pulse Flush -> writes 16'hABCD at address 0 and 16'hEF00 at address 1, then Done=1.
REQ-042 Overflow: with MAX_WORDS=2, send the header and 5 data bytes -> 2 writes, the fifth byte sets Overflow=1, and no third write occurs.
REQ-043 Consecutive strobes: Rx_valid on 4 consecutive cycles with bytes 01, 02, 03, 04 after the header -> writes 16'h0102 and 16'h0304, each with SRAM_we_n low for 1 cycle.
REQ-044 Reset mid-frame: assert Reset one cycle after the low byte's Rx_valid -> no write strobe occurs, and all outputs equal the REQ-037 values.
